// File: rtl/adpcm_xls_dec.sv
// IMA ADPCM decoder: consumes 4-bit codes (optionally packed two per byte) and
// rebuilds one signed 16-bit PCM sample per code on a registered valid/ready output.
module adpcm_xls_dec #(
    parameter bit PACKED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_code,
    input  logic               in_code_vld,
    output logic               in_code_rdy,
    input  logic               in_init,
    input  logic signed [15:0] in_init_pred,
    input  logic [6:0]         in_init_idx,
    output logic [15:0]        out_sample,
    output logic               out_sample_vld,
    input  logic               out_sample_rdy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [15:0] STEP_TAB [0:88] = '{
        16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
        16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
        16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
        16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
        16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
        16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
        16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
        16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
        16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
        16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
        16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
        16'd32767
    };

    function automatic logic [15:0] step_of(input logic [6:0] i);
        logic [15:0] s;
        if (i <= 7'd88) begin
            s = STEP_TAB[i];
        end else begin
            s = 16'd32767;
        end
        return s;
    endfunction

    function automatic logic signed [7:0] adj_of(input logic [2:0] c);
        logic signed [7:0] a;
        case (c)
            3'd4:    a = 8'sd2;
            3'd5:    a = 8'sd4;
            3'd6:    a = 8'sd6;
            3'd7:    a = 8'sd8;
            default: a = -8'sd1;
        endcase
        return a;
    endfunction

    state_t             state_r;
    logic [7:0]         buf_r;
    logic signed [15:0] pred_r;
    logic [6:0]         idx_r;
    logic [15:0]        out_sample_r;
    logic               out_vld_r;

    logic               out_load_s;
    logic               accept_s;
    logic [3:0]         code_s;
    logic [15:0]        step_s;
    logic [17:0]        diff_s;
    logic signed [18:0] sum_s;
    logic [15:0]        pred_next_s;
    logic signed [7:0]  idx_sum_s;
    logic [6:0]         idx_next_s;
    logic [6:0]         init_idx_s;

    assign out_load_s     = (!out_vld_r || out_sample_rdy) && (state_r != ST_EMPTY);
    assign in_code_rdy    = rst && !in_init &&
                            ((state_r == ST_EMPTY) || ((state_r == ST_ONE) && out_load_s));
    assign accept_s       = in_code_vld && in_code_rdy;
    assign out_sample     = out_sample_r;
    assign out_sample_vld = out_vld_r;

    // Decode the pending nibble against the current predictor state.
    always_comb begin
        code_s      = 4'd0;
        pred_next_s = 16'd0;
        idx_next_s  = 7'd0;
        if (state_r == ST_TWO) begin
            code_s = buf_r[3:0];
        end else if (PACKED) begin
            code_s = buf_r[7:4];
        end else begin
            code_s = buf_r[3:0];
        end
        step_s = step_of(idx_r);
        diff_s = {5'd0, step_s[15:3]}
               + (code_s[2] ? {2'd0, step_s} : 18'd0)
               + (code_s[1] ? {3'd0, step_s[15:1]} : 18'd0)
               + (code_s[0] ? {4'd0, step_s[15:2]} : 18'd0);
        sum_s  = code_s[3] ? ({{3{pred_r[15]}}, pred_r} - $signed({1'b0, diff_s}))
                           : ({{3{pred_r[15]}}, pred_r} + $signed({1'b0, diff_s}));
        if (sum_s > 19'sd32767) begin
            pred_next_s = 16'h7FFF;
        end else if (sum_s < -19'sd32768) begin
            pred_next_s = 16'h8000;
        end else begin
            pred_next_s = sum_s[15:0];
        end
        idx_sum_s = $signed({1'b0, idx_r}) + adj_of(code_s[2:0]);
        if (idx_sum_s < 8'sd0) begin
            idx_next_s = 7'd0;
        end else if (idx_sum_s > 8'sd88) begin
            idx_next_s = 7'd88;
        end else begin
            idx_next_s = idx_sum_s[6:0];
        end
        init_idx_s = (in_init_idx > 7'd88) ? 7'd88 : in_init_idx;
    end

    // Predictor, code buffer, pending-code FSM and output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_EMPTY;
            buf_r        <= 8'd0;
            pred_r       <= 16'sd0;
            idx_r        <= 7'd0;
            out_sample_r <= 16'd0;
            out_vld_r    <= 1'b0;
        end else if (in_init) begin
            // A held output sample survives init and can still be taken.
            pred_r  <= in_init_pred;
            idx_r   <= init_idx_s;
            state_r <= ST_EMPTY;
            if (out_vld_r && out_sample_rdy) begin
                out_vld_r <= 1'b0;
            end else begin
                out_vld_r <= out_vld_r;
            end
        end else begin
            if (out_load_s) begin
                out_sample_r <= pred_next_s;
                out_vld_r    <= 1'b1;
                pred_r       <= pred_next_s;
                idx_r        <= idx_next_s;
            end else if (out_sample_rdy) begin
                out_vld_r <= 1'b0;
            end else begin
                out_vld_r <= out_vld_r;
            end
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        buf_r   <= in_code;
                        state_r <= PACKED ? ST_TWO : ST_ONE;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_load_s) begin
                        state_r <= ST_ONE;
                    end else begin
                        state_r <= ST_TWO;
                    end
                end
                ST_ONE: begin
                    if (out_load_s && accept_s) begin
                        buf_r   <= in_code;
                        state_r <= PACKED ? ST_TWO : ST_ONE;
                    end else if (out_load_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                default: state_r <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_adpcm_xls_dec.sv
// Directed bench for adpcm_xls_dec: an integer IMA reference model fills an expected
// sample queue; one compare process checks every output transfer against it.
module tb_adpcm_xls_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_code;
    logic        in_code_vld;
    logic        in_code_rdy;
    logic        in_init;
    logic [15:0] in_init_pred;
    logic [6:0]  in_init_idx;
    logic [15:0] out_sample;
    logic        out_sample_vld;
    logic        out_sample_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];
    int got[$];
    int pop_cyc[$];
    int m_pred = 0;
    int m_idx  = 0;
    logic        held_vld = 1'b0;
    logic [15:0] held_val = 16'd0;

    int step_tab[89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
        1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
        3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
        12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };
    int adj_tab[8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    adpcm_xls_dec #(.PACKED(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_code        (in_code),
        .in_code_vld    (in_code_vld),
        .in_code_rdy    (in_code_rdy),
        .in_init        (in_init),
        .in_init_pred   (in_init_pred),
        .in_init_idx    (in_init_idx),
        .out_sample     (out_sample),
        .out_sample_vld (out_sample_vld),
        .out_sample_rdy (out_sample_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference IMA decode of one code, in plain integer arithmetic.
    function automatic void m_dec(input int c);
        int st;
        int d;
        st = step_tab[m_idx];
        d  = st / 8;
        if ((c & 4) != 0) d += st;
        if ((c & 2) != 0) d += st / 2;
        if ((c & 1) != 0) d += st / 4;
        m_pred = ((c & 8) != 0) ? m_pred - d : m_pred + d;
        if (m_pred > 32767)  m_pred = 32767;
        if (m_pred < -32768) m_pred = -32768;
        m_idx += adj_tab[c & 7];
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 88) m_idx = 88;
        exp_q.push_back(m_pred & 32'hFFFF);
    endfunction

    // Output-side checker: every transfer is compared, held samples must not move.
    always @(negedge clk) begin
        if (held_vld && rst) chk("hold_stable", out_sample, held_val);
        if (rst && out_sample_vld && out_sample_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", out_sample, -1);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("sample", out_sample, e);
            end
            got.push_back(out_sample);
            pop_cyc.push_back(cyc);
        end
        held_vld = rst && out_sample_vld && !out_sample_rdy;
        held_val = out_sample;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_code     = b;
        in_code_vld = 1'b1;
        @(negedge clk);
        while (!in_code_rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_code_rdy) begin
            chk("accept_timeout", 0, 1);
        end else begin
            m_dec(b[3:0]);
            m_dec(b[7:4]);
        end
        @(posedge clk);
        #1;
        in_code_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_sample_vld) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || out_sample_vld) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        m_pred = 0;
        m_idx  = 0;
    endtask

    task automatic do_init(input logic [15:0] p, input logic [6:0] i);
        in_init      = 1'b1;
        in_init_pred = p;
        in_init_idx  = i;
        @(posedge clk);
        #1 in_init = 1'b0;
        m_pred = int'($signed(p));
        m_idx  = (i > 7'd88) ? 88 : int'(i);
    endtask

    initial begin
        rst            = 1'b0;
        in_code        = 8'h00;
        in_code_vld    = 1'b1;
        in_init        = 1'b0;
        in_init_pred   = 16'h0000;
        in_init_idx    = 7'd0;
        out_sample_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", out_sample_vld, 0);
        chk("rst_sample", out_sample, 0);
        chk("rst_in_rdy", in_code_rdy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        in_code_vld = 1'b0;

        // Basic decode and first-sample latency
        got.delete();
        send_byte(8'hC4);
        @(negedge clk);
        chk("lat_vld_early", out_sample_vld, 0);
        @(negedge clk);
        chk("lat_vld", out_sample_vld, 1);
        chk("lat_sample", out_sample, 16'h0007);
        drain();
        chk("basic_cnt", got.size(), 2);
        if (got.size() == 2) begin
            chk("basic_s0", got[0], 16'h0007);
            chk("basic_s1", got[1], 16'hFFFD);
        end
        chk("basic_model_idx", m_idx, 4);

        // Index floor
        do_reset();
        got.delete();
        send_byte(8'h00);
        send_byte(8'h44);
        drain();
        chk("floor_cnt", got.size(), 4);
        if (got.size() == 4) begin
            chk("floor_s0", got[0], 16'h0000);
            chk("floor_s1", got[1], 16'h0000);
            chk("floor_s2", got[2], 16'h0007);
            chk("floor_s3", got[3], 16'h0011);
        end

        // Saturation with an out-of-range init index
        got.delete();
        do_init(16'h7FFF, 7'd127);
        send_byte(8'hF7);
        chk("sat_model_idx", m_idx, 88);
        send_byte(8'h70);
        drain();
        chk("sat_cnt", got.size(), 4);
        if (got.size() == 4) begin
            chk("sat_s0", got[0], 16'h7FFF);
            chk("sat_s1", got[1], 16'h9003);
            chk("sat_s2", got[2], 16'hA002);
            chk("sat_s3", got[3], 16'h7A39);
        end

        // Backpressure: first sample held for 5 cycles
        do_reset();
        got.delete();
        out_sample_rdy = 1'b0;
        send_byte(8'h3A);
        in_code     = 8'h5B;
        in_code_vld = 1'b1;
        for (int n = 0; n < 20 && !out_sample_vld; n++) @(negedge clk);
        chk("bp_first_vld", out_sample_vld, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_rdy", in_code_rdy, 0);
            chk("bp_vld", out_sample_vld, 1);
        end
        @(posedge clk);
        #1 out_sample_rdy = 1'b1;
        send_byte(8'h5B);
        drain();
        chk("bp_cnt", got.size(), 4);

        // Throughput: 256 random bytes, one sample per cycle
        do_reset();
        got.delete();
        pop_cyc.delete();
        for (int k = 0; k < 256; k++) send_byte(8'($urandom_range(0, 255)));
        drain();
        chk("tp_cnt", got.size(), 512);
        if (pop_cyc.size() == 512) chk("tp_span", pop_cyc[511] - pop_cyc[0], 511);

        // Init while both nibbles pending discards them
        got.delete();
        send_byte(8'h77);
        do_init(16'h1000, 7'd10);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        send_byte(8'h21);
        drain();
        chk("init_cnt", got.size(), 2);
        if (got.size() == 2) begin
            chk("init_s0", got[0], 16'h1006);
            chk("init_s1", got[1], 16'h1010);
        end

        // Reset mid-stream drops the held sample and pending nibble
        got.delete();
        send_byte(8'h77);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_vld_before", out_sample_vld, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        m_pred = 0;
        m_idx  = 0;
        @(negedge clk);
        chk("mid_rst_vld", out_sample_vld, 0);
        chk("mid_rst_sample", out_sample, 0);
        @(posedge clk);
        #1;
        send_byte(8'hC4);
        drain();
        chk("mid_cnt", got.size(), 2);
        if (got.size() == 2) begin
            chk("mid_s0", got[0], 16'h0007);
            chk("mid_s1", got[1], 16'hFFFD);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/adpcm_xls_dec.md
# adpcm_xls_dec

IMA ADPCM decoder: receiver-side counterpart of the `adpcm_xls` encoder. It accepts 4-bit ADPCM codes, packed two per byte, over a valid/ready stream. It reconstructs one signed 16-bit PCM sample per code over a valid/ready output stream. Its step table, index-adjust table, and predictor/index update rules are bit-identical to the encoder's, so a decoder fed the encoder's code stream tracks the encoder's predictor exactly.

## Interface
- `PACKED`, default 1: 1 = each input byte carries two codes, low nibble first; 0 = one code in `in_code[3:0]`, with `[7:4]` ignored.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: one clock; reset is synchronous and active-low (0 = reset).
- `in_code` input 8: packed ADPCM code byte.
- `in_code_vld` input 1: `in_code` valid.
- `in_code_rdy` output 1: decoder accepts `in_code` this cycle.
- `in_init` input 1: single-cycle request to load the predictor state.
- `in_init_pred` input 16: signed predictor load value.
- `in_init_idx` input 7: step-index load value; clamped to 88.
- `out_sample` output 16: reconstructed signed PCM sample (registered).
- `out_sample_vld` output 1: `out_sample` valid (registered).
- `out_sample_rdy` input 1: downstream accepts `out_sample`.

## Operation
- **State registers**
  - `pred`: signed 16 bits.
  - `idx`: 7 bits, range 0..88.
  - Code buffer: 8 bits.
  - Pending-code FSM.
  - Output register and its valid bit.
- **Step table**: 89 entries, 7, 8, 9 … 0x7462, 0x7FFF. Identical to the encoder table.
- **Index-adjust table** for `c[2:0]` = 0..7: −1, −1, −1, −1, +2, +4, +6, +8.
- **Decode of code `c`**, with `step` = table[`idx`]:
  - diff = step>>3, + step if c[2], + step>>1 if c[1], + step>>2 if c[0]. Computed unsigned, at least 18 bits wide.
  - t = pred − diff if c[3], else pred + diff. Computed signed, at least 19 bits wide.
  - pred ← clamp(t, −32768, 32767).
  - idx ← clamp(idx + adj[c[2:0]], 0, 88).
  - The sample emitted is the new `pred`.
- **FSM**:
  - `EMPTY`: no code pending.
  - `TWO`: both nibbles of the buffered byte are pending.
  - `ONE`: only the high nibble is pending (PACKED=1), or the single code is pending (PACKED=0).
- **Definitions**:
  - `out_load` = (`!out_sample_vld` | `out_sample_rdy`) & (state ≠ `EMPTY`).
  - `accept` = `in_code_vld` & `in_code_rdy`.
  - `in_code_rdy` = `rst` & `!in_init` & (state == `EMPTY` | (state == `ONE` & `out_load`)).
- **Transitions**:
  - `EMPTY` + `accept` → `TWO` (PACKED=1) or `ONE` (PACKED=0).
  - `TWO` + `out_load` → `ONE`; the low nibble is decoded.
  - `ONE` + `out_load` → `EMPTY`, or → `TWO`/`ONE` if `accept` in the same cycle; the high nibble (or single code) is decoded.
- On `out_load`: the decoded sample is written to `out_sample`, `out_sample_vld` ← 1, and `pred`/`idx` are updated.
- With `out_sample_vld` & `out_sample_rdy` & !`out_load`: `out_sample_vld` ← 0.
- **`in_init` is highest priority**:
  - `pred` ← `in_init_pred`.
  - `idx` ← min(`in_init_idx`, 88).
  - FSM ← `EMPTY`; pending codes are discarded.
  - No decode occurs in that cycle.
  - The output register and its valid bit are unaffected: a held sample remains valid until taken.

## Timing
- **Reset** (`rst` = 0, sampled at a clock edge):
  - `pred` = 0, `idx` = 0, FSM = `EMPTY`.
  - `out_sample` = 0, `out_sample_vld` = 0.
  - `in_code_rdy` = 0 while `rst` = 0.
- Reset mid-stream drops the pending codes and the output sample.
- **Latency**: a byte accepted at edge N yields sample 0 valid after edge N+1. Sample 1 is valid after edge N+2 if sample 0 is taken at N+2.
- **Throughput**: one sample per cycle sustained with `out_sample_rdy` = 1.
  - PACKED=1: one byte every 2 cycles, enabled by the `ONE` + `out_load` accept path.
  - PACKED=0: one byte per cycle.
- **Backpressure**: while `out_sample_vld` = 1 and `out_sample_rdy` = 0:
  - `out_sample` holds stable.
  - `pred`/`idx` do not change.
  - `in_code_rdy` = 0 unless the state is `EMPTY`.
- `in_code` is sampled only on `accept`; its value is don't-care otherwise.

## Test plan
- **Basic decode**: after reset, PACKED=1, byte 0xC4 → `out_sample` 0x0007, then 0xFFFD; final `idx` = 4.
- **Saturation**: `in_init` with pred 0x7FFF and idx 127, then byte 0xF7 → 0x7FFF, then 0x9003; `idx` stays 88; `in_init_idx` 127 must have been clamped to 88.
- **Index floor**: after reset, byte 0x00 → 0x0000, 0x0000; `idx` stays 0.
- **Backpressure**: `out_sample_rdy` held 0 for 5 cycles after the first sample.
  - `out_sample` is stable and `in_code_rdy` = 0.
  - On release, the remaining samples appear in order with no loss or duplication.
- **Throughput and equivalence**: 256 random bytes with `out_sample_rdy` = 1 → 512 samples in 512 consecutive cycles, matching a C IMA reference model and the encoder's `out_pred` for the same stream.
- **Mid-stream init/reset**:
  - `in_init` asserted while in `TWO` → the pending nibbles are never emitted, and the next byte decodes from the loaded state.
  - `rst` = 0 for 1 cycle mid-stream → `out_sample_vld` = 0 on the next cycle, and decoding restarts from pred 0 / idx 0.
